// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Control unit for the accumulator datapath. Fetches 8-bit
//               instructions over a req/ack memory port, owns the program
//               counter, and emits one-cycle EXEC strobes to the ALU,
//               accumulator, register file and carry register.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    input  logic            cy,
    output logic [3:0]      alu_op,
    output logic            alu_ci,
    output logic            b_sel,
    output logic [7:0]      imm,
    output logic [3:0]      reg_addr,
    output logic            acc_we,
    output logic            reg_we,
    output logic            cy_ce,
    output logic            cy_clr,
    output logic            halted
);

    localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] c_pc_one   = PC_W'(1);

    // Controller states
    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_fetch2 = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_halt   = 3'd4;

    // Opcodes that need special handling in the sequencer / strobe logic
    localparam logic [3:0] c_op_add = 4'h0;
    localparam logic [3:0] c_op_adc = 4'h1;
    localparam logic [3:0] c_op_sub = 4'h2;
    localparam logic [3:0] c_op_sbc = 4'h3;
    localparam logic [3:0] c_op_and = 4'h4;
    localparam logic [3:0] c_op_or  = 4'h5;
    localparam logic [3:0] c_op_xor = 4'h6;
    localparam logic [3:0] c_op_not = 4'h7;
    localparam logic [3:0] c_op_mov = 4'h8;
    localparam logic [3:0] c_op_ldi = 4'h9;
    localparam logic [3:0] c_op_jmp = 4'hA;
    localparam logic [3:0] c_op_jc  = 4'hB;
    localparam logic [3:0] c_op_st  = 4'hC;
    localparam logic [3:0] c_op_clc = 4'hD;
    localparam logic [3:0] c_op_hlt = 4'hF;

    logic [2:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_instr;
    logic [7:0]      r_imm;

    logic [3:0]      w_opcode;
    logic            w_exec;
    logic [PC_W-1:0] w_target;
    logic [3:0]      w_alu_op;

    assign w_opcode = r_instr[7:4];
    assign w_exec   = (r_state == c_st_exec);

    // Jump target is the operand byte, truncated or zero-extended to PC width
    generate
        if (PC_W <= 8) begin : g_tgt_narrow
            assign w_target = r_imm[PC_W-1:0];
        end else begin : g_tgt_wide
            assign w_target = {{(PC_W-8){1'b0}}, r_imm};
        end
    endgenerate

    // Sequencer: fetch, decode, optional operand fetch, execute, halt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_fetch;
            r_pc    <= c_reset_pc;
            r_instr <= 8'h00;
            r_imm   <= 8'h00;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (mem_ack) begin
                        r_instr <= mem_rdata;
                        r_pc    <= r_pc + c_pc_one;
                        r_state <= c_st_decode;
                    end
                end
                c_st_decode: begin
                    if (w_opcode == c_op_hlt) begin
                        r_state <= c_st_halt;
                    end else if (w_opcode == c_op_ldi || w_opcode == c_op_jmp ||
                                 w_opcode == c_op_jc) begin
                        r_state <= c_st_fetch2;
                    end else begin
                        r_state <= c_st_exec;
                    end
                end
                c_st_fetch2: begin
                    if (mem_ack) begin
                        r_imm   <= mem_rdata;
                        r_pc    <= r_pc + c_pc_one;
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    // Branch condition uses the carry as seen during EXEC
                    if (w_opcode == c_op_jmp || (w_opcode == c_op_jc && cy)) begin
                        r_pc <= w_target;
                    end
                    r_state <= c_st_fetch;
                end
                c_st_halt: begin
                    r_state <= c_st_halt;
                end
                default: begin
                    r_state <= c_st_fetch;
                end
            endcase
        end
    end

    // ALU opcode map; held stable from the latched instruction in every state
    always_comb begin
        w_alu_op = 4'b0000;
        case (w_opcode)
            c_op_add, c_op_adc: w_alu_op = 4'b0000;
            c_op_sub, c_op_sbc: w_alu_op = 4'b0001;
            c_op_and:           w_alu_op = 4'b0010;
            c_op_or:            w_alu_op = 4'b0011;
            c_op_xor:           w_alu_op = 4'b0100;
            c_op_not:           w_alu_op = 4'b0101;
            c_op_mov, c_op_ldi: w_alu_op = 4'b0110;
            default:            w_alu_op = 4'b0000;
        endcase
    end

    assign alu_op   = w_alu_op;
    assign alu_ci   = (w_opcode == c_op_adc || w_opcode == c_op_sbc) & cy;
    assign b_sel    = (w_opcode == c_op_ldi);
    assign imm      = r_imm;
    assign reg_addr = r_instr[3:0];

    // Datapath strobes exist only during the single EXEC cycle
    assign acc_we = w_exec & (w_opcode <= c_op_ldi);
    assign reg_we = w_exec & (w_opcode == c_op_st);
    assign cy_ce  = w_exec & (w_opcode == c_op_add || w_opcode == c_op_adc ||
                              w_opcode == c_op_clc);
    assign cy_clr = w_exec & (w_opcode == c_op_clc);

    assign mem_req  = (r_state == c_st_fetch) || (r_state == c_st_fetch2);
    assign mem_addr = r_pc;
    assign halted   = (r_state == c_st_halt);

endmodule
`default_nettype wire
